tri_wb_loader: RTL

Wishbone initiator that loads one triangle setup record (four 32-bit words) into a selected `interp_tri` slot. It accepts a command on a valid/ready interface and writes the words to register indices 0..3. It drives the per-slot decoded strobe vector and waits for that slot's acknowledge. It is the initiator end of the slot bus that the `interp_tri` array responds on, so the engine can refill slots without going through the management SoC.

---
 rtl/tri_wb_loader.sv | 83 ++++++++
 1 files changed

// File: rtl/tri_wb_loader.sv
// tri_wb_loader: Wishbone initiator that writes a four-word triangle setup record
// into one interp_tri slot through a one-hot decoded strobe/ack vector.
module tri_wb_loader #(
  parameter int NSLOTS = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_slot,
  input  logic [127:0]      cmd_words,
  output logic              wbm_cyc_o,
  output logic [NSLOTS-1:0] wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [1:0]        wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic [NSLOTS-1:0] wbm_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_d;
  logic [3:0][31:0] words;
  logic [7:0] cnt;
  logic accept, slot_ok, go, ack, last, tmo;
  always_comb begin
    accept = cmd_valid & cmd_ready;
    slot_ok = 32'(cmd_slot) < NSLOTS;
    go = accept & slot_ok;
    // the registered strobe is one-hot on the target slot, so masking isolates its ack
    ack = |(wbm_ack_i & wbm_stb_o);
    last = wbm_adr_o == 2'd3;
    tmo = cnt == 8'(TIMEOUT - 1);
    state_d = state;
    case (state)
      IDLE:    state_d = go ? WRITE : IDLE;
      WRITE:   state_d = ack ? (last ? DONE : WRITE) : (tmo ? IDLE : WRITE);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      words     <= '0;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 2'd0;
      wbm_dat_o <= 32'd0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state     <= state_d;
      cmd_ready <= state_d == IDLE;
      busy_o    <= state_d != IDLE;
      done_o    <= state_d == DONE;
      wbm_cyc_o <= state_d == WRITE;
      wbm_we_o  <= state_d == WRITE;
      wbm_sel_o <= {4{state_d == WRITE}};
      wbm_stb_o <= state_d != WRITE ? '0 : go ? NSLOTS'(1) << cmd_slot : wbm_stb_o;
      cnt       <= (state != WRITE || ack) ? 8'd0 : cnt + 8'd1;
      if (go) begin
        words     <= cmd_words;
        wbm_adr_o <= 2'd0;
        wbm_dat_o <= cmd_words[31:0];
      end else if (state == WRITE && ack && !last) begin
        wbm_adr_o <= wbm_adr_o + 2'd1;
        wbm_dat_o <= words[wbm_adr_o + 2'd1];
      end
      if (accept)
        err_o <= !slot_ok;
      else if (state == WRITE && !ack && tmo)
        err_o <= 1'b1;
    end
  end
endmodule
